mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and stall source for the five-stage pipeline. It shares one external SRAM-style bus between the instruction fetch port (driven by `pc`) and the MEM-stage data port. It sequences each access through a request/acknowledge handshake with timeout protection. It drives the `stall` vector that freezes the pipeline stages while an access is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles a granted access may wait for `bus_ack` before it is aborted. A value of 0 disables the timeout.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  instruction fetch request; held until `if_valid`.
- `if_addr`  in  32  fetch address.
- `if_rdata`  out  32  fetched instruction; valid while `if_valid`=1.
- `if_valid`  out  1  one-cycle completion pulse for the fetch.
- `mem_req`  in  1  data access request; held until `mem_valid`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_sel`  in  4  byte enables.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  write data.
- `mem_rdata`  out  32  read data; valid while `mem_valid`=1.
- `mem_valid`  out  1  one-cycle completion pulse for the data access.
- `bus_req`, `bus_we`, `bus_sel[3:0]`, `bus_addr[31:0]`, `bus_wdata[31:0]`  out  registered bus command.
- `bus_rdata`  in  32  bus read data; sampled when `bus_ack`=1.
- `bus_ack`  in  1  slave completion.
- `bus_err`  out  1  one-cycle pulse when an access times out.
- `stall`  out  6  stage freeze vector. Bit 0 = PC, bit 1 = IF, bit 2 = ID, bit 3 = EX, bit 4 = MEM, bit 5 = WB.

## Operation
- The FSM has three states: IDLE, DBUS and IBUS. It also holds a one-bit `last_grant` flag (D or I) and a timeout counter wide enough for `TIMEOUT_CYCLES`.
- Behaviour in IDLE:
  - A request counts as eligible if its req is 1 and its own valid is not high in this cycle. A requester is never re-granted in the cycle its valid pulses.
  - If both requests are eligible, choose DBUS unless `last_grant`=D, in which case choose IBUS. Otherwise grant whichever single request is eligible.
  - On a grant, latch the command fields into the `bus_*` registers, set `bus_req`=1 and clear the counter.
- Behaviour in DBUS and IBUS:
  - The `bus_*` registers stay stable until the access ends, and the counter increments each cycle.
  - When `bus_ack`=1:
    - Capture `bus_rdata` into the granted requester's rdata. For writes, rdata is set to 0.
    - Pulse that requester's valid for one cycle, set `bus_req`=0, update `last_grant` and return to IDLE.
  - When the counter reaches `TIMEOUT_CYCLES-1` and `bus_ack`=0:
    - Abort the access: rdata is set to 0 and valid pulses as normal.
    - `bus_err` pulses together with valid, `bus_req`=0 and the FSM returns to IDLE.
- `bus_ack` is ignored in IDLE.
- `stall` is combinational from the registered state and the request inputs:
  - A data access is pending when `mem_req`=1 and `mem_valid`=0. This drives `stall` = 6'b011111; WB drains.
  - A fetch is pending otherwise when `if_req`=1 and `if_valid`=0. This drives `stall` = 6'b000011; ID receives a bubble.
  - With neither pending, `stall` = 0.
- Reset mid-access drops `bus_req` immediately, asynchronously. No completion pulse is issued.

## Timing
- Reset values: every output is 0, state = IDLE, `last_grant` = I, so data wins the first tie.
- Grant latency: a request seen in cycle N produces `bus_req`=1 in cycle N+1.
- Completion: `bus_ack` in cycle M produces valid and rdata in cycle M+1, and `stall` deasserts in that same M+1 cycle.
- The minimum access is 2 cycles from req to valid, with `bus_ack` asserted in the same cycle as `bus_req`.
- Back-to-back accesses: the next grant occurs at the earliest in the cycle after valid, giving 3 cycles per access.
- A timeout fires so that valid appears `TIMEOUT_CYCLES`+1 cycles after the grant cycle.
- Valid pulses are exactly one cycle long, and `if_valid` and `mem_valid` are never high in the same cycle.

## Structure
- Bus widths (`RegBus`, `InstAddrBus`) come from `defines.v`.
- The following are added to `defines.v`: state encodings `ArbIdle`, `ArbDbus`, `ArbIbus`; the stall patterns `StallData` = 6'b011111 and `StallInst` = 6'b000011; and `StallNone`.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Reset with `if_req`=1 held low-reset → all outputs 0. After release, `bus_req`=1 one cycle later with `bus_addr` = `if_addr`.
- Fetch read, `if_addr`=0x00000004, ack delayed 3 cycles with `bus_rdata`=0x34011100 → `if_valid` pulses with that word, and `stall`=6'b000011 until the pulse.
- Simultaneous `mem_req` (write 0xDEADBEEF @0x100, sel=4'hF) and `if_req` → DBUS first with `stall`=6'b011111. `mem_rdata`=0, then IBUS is granted next.
- Sustained `mem_req` and `if_req` across 4 accesses → grants alternate D,I,D,I, and neither requester is re-granted in its valid cycle.
- `TIMEOUT_CYCLES`=4 with no ack → `mem_valid` and `bus_err` pulse 5 cycles after the grant, `mem_rdata`=0, FSM returns to IDLE.
- `rst` asserted while in DBUS → `bus_req` drops immediately, no `mem_valid`, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state, grant and stall encodings shared by the memory arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_DBUS = 2'd1;
  localparam logic [1:0] ARB_IBUS = 2'd2;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_DATA = 6'b011111;
  localparam logic [5:0] STALL_INST = 6'b000011;
  typedef struct packed {
    logic we;
    logic [3:0] sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port, external bus and stall vector of the arbiter
interface mem_arbiter_if;
  logic if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic if_valid;
  logic mem_req;
  logic mem_we;
  logic [3:0] mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic mem_valid;
  logic bus_req;
  logic bus_we;
  logic [3:0] bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_ack;
  logic bus_err;
  logic [5:0] stall;
  modport slave (
    input if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
    output if_rdata, if_valid, mem_rdata, mem_valid, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output bus_err, stall
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
    input if_rdata, if_valid, mem_rdata, mem_valid, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input bus_err, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-style bus between fetch and data ports, with timeout and pipeline stall
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave b
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [1:0] state;
  logic last_grant;
  logic [CW-1:0] cnt;
  logic d_elig, i_elig, pick_d, pick_i, timeout, done;
  bus_cmd_t cmd;
  always_comb begin
    d_elig = b.mem_req && !b.mem_valid;
    i_elig = b.if_req && !b.if_valid;
    pick_d = d_elig && !(i_elig && last_grant == GRANT_D);
    pick_i = i_elig && !pick_d;
    cmd = pick_d ? '{b.mem_we, b.mem_sel, b.mem_addr, b.mem_wdata} : '{1'b0, 4'hF, b.if_addr, 32'h0};
    timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1) && !b.bus_ack;
    done = state != ARB_IDLE && (b.bus_ack || timeout);
    // held at zero during reset even if a requester is already asserting
    b.stall = !rst ? STALL_NONE : d_elig ? STALL_DATA : i_elig ? STALL_INST : STALL_NONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      last_grant <= GRANT_I;
      cnt <= '0;
      b.bus_req <= 1'b0;
      b.bus_we <= 1'b0;
      b.bus_sel <= '0;
      b.bus_addr <= '0;
      b.bus_wdata <= '0;
      b.bus_err <= 1'b0;
      b.if_rdata <= '0;
      b.if_valid <= 1'b0;
      b.mem_rdata <= '0;
      b.mem_valid <= 1'b0;
    end else begin
      b.if_valid <= 1'b0;
      b.mem_valid <= 1'b0;
      b.bus_err <= 1'b0;
      if (state == ARB_IDLE) begin
        if (pick_d || pick_i) begin
          state <= pick_d ? ARB_DBUS : ARB_IBUS;
          b.bus_req <= 1'b1;
          {b.bus_we, b.bus_sel, b.bus_addr, b.bus_wdata} <= cmd;
          cnt <= '0;
        end
      end else if (done) begin
        state <= ARB_IDLE;
        b.bus_req <= 1'b0;
        b.bus_err <= timeout;
        last_grant <= state == ARB_DBUS ? GRANT_D : GRANT_I;
        if (state == ARB_DBUS) begin
          b.mem_valid <= 1'b1;
          b.mem_rdata <= (timeout || b.bus_we) ? '0 : b.bus_rdata;
        end else begin
          b.if_valid <= 1'b1;
          b.if_rdata <= timeout ? '0 : b.bus_rdata;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, hand sequences and a random run against a transaction model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if b();
  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .b(b));
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic is_mem;
    logic we;
    logic [3:0] sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int delay;
    logic [31:0] exp_rdata;
    logic exp_err;
    int exp_lat;
  } vec_t;
  vec_t vt[8];
  logic [31:0] grants[$];
  int owner, gcyc, dly, cyc, done_cnt;
  logic last_d, e_breq, e_bwe, e_ivalid, e_mvalid, e_err, nv_i, nv_m, de, ie;
  logic [3:0] e_bsel;
  logic [31:0] e_baddr, e_bwdata, e_irdata, e_mrdata;
  logic [5:0] e_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    b.if_req = 1'b0; b.if_addr = '0;
    b.mem_req = 1'b0; b.mem_we = 1'b0; b.mem_sel = '0; b.mem_addr = '0; b.mem_wdata = '0;
    b.bus_ack = 1'b0; b.bus_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic got;
    logic [5:0] want;
    got = 1'b0;
    want = v.is_mem ? STALL_DATA : STALL_INST;
    if (v.is_mem) begin
      b.mem_req = 1'b1; b.mem_we = v.we; b.mem_sel = v.sel; b.mem_addr = v.addr; b.mem_wdata = v.wdata;
    end else begin
      b.if_req = 1'b1; b.if_addr = v.addr;
    end
    #1;
    check($sformatf("v%0d_stall", idx), 32'(b.stall), 32'(want));
    for (int k = 1; k <= 12 && !got; k++) begin
      tick();
      b.bus_ack = 1'b0;
      if (k == 1) begin
        check($sformatf("v%0d_grant", idx), 32'(b.bus_req), 1);
        check($sformatf("v%0d_bus_addr", idx), b.bus_addr, v.addr);
        check($sformatf("v%0d_bus_we", idx), 32'(b.bus_we), 32'(v.is_mem && v.we));
        if (v.is_mem) begin
          check($sformatf("v%0d_bus_sel", idx), 32'(b.bus_sel), 32'(v.sel));
          check($sformatf("v%0d_bus_wdata", idx), b.bus_wdata, v.wdata);
        end
      end
      if ((v.is_mem ? b.mem_valid : b.if_valid) === 1'b1) begin
        got = 1'b1;
        check($sformatf("v%0d_latency", idx), 32'(k), 32'(v.exp_lat));
        check($sformatf("v%0d_rdata", idx), v.is_mem ? b.mem_rdata : b.if_rdata, v.exp_rdata);
        check($sformatf("v%0d_bus_err", idx), 32'(b.bus_err), 32'(v.exp_err));
        check($sformatf("v%0d_other_valid", idx), 32'(v.is_mem ? b.if_valid : b.mem_valid), 0);
        check($sformatf("v%0d_bus_req_drop", idx), 32'(b.bus_req), 0);
        #1;
        check($sformatf("v%0d_stall_release", idx), 32'(b.stall), 0);
        b.mem_req = 1'b0; b.if_req = 1'b0;
      end else begin
        b.bus_ack = (k - 1 == v.delay);
        b.bus_rdata = b.bus_ack ? v.rdata : $urandom();
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL v%0d_valid: no completion within 12 cycles", idx);
    end
    b.bus_ack = 1'b0; b.mem_req = 1'b0; b.if_req = 1'b0;
    tick();
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 4'hF, 32'h4, 32'h0, 32'h34011100, 3, 32'h34011100, 1'b0, 5};
    vt[1] = '{1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h13572468, 0, 32'h0, 1'b0, 2};
    vt[2] = '{1'b1, 1'b0, 4'h3, 32'h200, 32'h0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0, 3};
    vt[3] = '{1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h12345678, 0, 32'h12345678, 1'b0, 2};
    vt[4] = '{1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 32'hFFFFFFFF, 99, 32'h0, 1'b1, 5};
    vt[5] = '{1'b0, 1'b0, 4'hF, 32'hC, 32'h0, 32'h87654321, 99, 32'h0, 1'b1, 5};
    vt[6] = '{1'b1, 1'b1, 4'hC, 32'h404, 32'h0BADF00D, 32'hAAAA5555, 2, 32'h0, 1'b0, 4};
    vt[7] = '{1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 32'h600DCAFE, 3, 32'h600DCAFE, 1'b0, 5};
    idle_in();
    // reset held with a fetch already requesting
    b.if_req = 1'b1; b.if_addr = 32'h40;
    repeat (2) tick();
    check("rst_bus_req", 32'(b.bus_req), 0);
    check("rst_bus_addr", b.bus_addr, 0);
    check("rst_if_valid", 32'(b.if_valid), 0);
    check("rst_mem_valid", 32'(b.mem_valid), 0);
    check("rst_bus_err", 32'(b.bus_err), 0);
    check("rst_stall", 32'(b.stall), 0);
    rst = 1'b1;
    tick();
    check("rel_bus_req", 32'(b.bus_req), 1);
    check("rel_bus_addr", b.bus_addr, 32'h40);
    b.bus_ack = 1'b1; b.bus_rdata = 32'h11;
    tick();
    b.bus_ack = 1'b0;
    check("rel_if_valid", 32'(b.if_valid), 1);
    check("rel_if_rdata", b.if_rdata, 32'h11);
    b.if_req = 1'b0;
    tick();
    // simultaneous requests: data first, fetch granted in the data valid cycle
    b.mem_req = 1'b1; b.mem_we = 1'b1; b.mem_sel = 4'hF; b.mem_addr = 32'h100; b.mem_wdata = 32'hDEADBEEF;
    b.if_req = 1'b1; b.if_addr = 32'h20;
    #1;
    check("tie_stall", 32'(b.stall), 32'(6'b011111));
    tick();
    check("tie_d_addr", b.bus_addr, 32'h100);
    check("tie_d_we", 32'(b.bus_we), 1);
    check("tie_d_wdata", b.bus_wdata, 32'hDEADBEEF);
    b.bus_ack = 1'b1; b.bus_rdata = 32'h99999999;
    tick();
    b.bus_ack = 1'b0;
    check("tie_mem_valid", 32'(b.mem_valid), 1);
    check("tie_mem_rdata", b.mem_rdata, 0);
    #1;
    check("tie_stall_inst", 32'(b.stall), 32'(6'b000011));
    b.mem_req = 1'b0;
    tick();
    check("tie_i_grant", 32'(b.bus_req), 1);
    check("tie_i_addr", b.bus_addr, 32'h20);
    b.bus_ack = 1'b1; b.bus_rdata = 32'h55;
    tick();
    b.bus_ack = 1'b0;
    check("tie_if_valid", 32'(b.if_valid), 1);
    check("tie_if_rdata", b.if_rdata, 32'h55);
    b.if_req = 1'b0;
    tick();
    // sustained requests alternate between the ports
    b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_addr = 32'h300; b.if_req = 1'b1; b.if_addr = 32'h400;
    done_cnt = 0;
    for (int k = 0; k < 30 && done_cnt < 4; k++) begin
      tick();
      b.bus_ack = 1'b0;
      if (b.mem_valid && b.if_valid) begin
        n_chk++; n_fail++;
        $display("FAIL alt_both_valid: got both valids high expected at most one");
      end
      if (b.mem_valid || b.if_valid) done_cnt++;
      if (done_cnt == 4) begin
        b.mem_req = 1'b0; b.if_req = 1'b0;
      end
      if (b.bus_req) begin
        grants.push_back(b.bus_addr);
        b.bus_ack = 1'b1; b.bus_rdata = $urandom();
      end
    end
    b.bus_ack = 1'b0; b.mem_req = 1'b0; b.if_req = 1'b0;
    check("alt_count", 32'(grants.size()), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check($sformatf("alt_grant%0d", k), grants[k], (k % 2 == 0) ? 32'h300 : 32'h400);
    tick();
    for (int i = 0; i < 8; i++) run_vec(vt[i], i);
    // reset while a data access is outstanding
    b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_addr = 32'h500;
    tick();
    check("mid_grant", 32'(b.bus_req), 1);
    #1; rst = 1'b0; #1;
    check("mid_bus_req_async", 32'(b.bus_req), 0);
    b.mem_req = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_no_valid%0d", k), 32'(b.mem_valid), 0);
    end
    b.if_req = 1'b1; b.if_addr = 32'h600;
    tick();
    check("mid_idle_grant", 32'(b.bus_req), 1);
    check("mid_idle_addr", b.bus_addr, 32'h600);
    b.bus_ack = 1'b1; b.bus_rdata = 32'h77;
    tick();
    b.bus_ack = 1'b0;
    check("mid_if_valid", 32'(b.if_valid), 1);
    b.if_req = 1'b0;
    tick();
    // random traffic against a transaction-level model, starting from reset
    rst = 1'b0; idle_in();
    tick();
    rst = 1'b1;
    owner = 0; gcyc = 0; dly = 0; cyc = 0; last_d = 1'b0;
    e_breq = 0; e_bwe = 0; e_ivalid = 0; e_mvalid = 0; e_err = 0;
    e_bsel = '0; e_baddr = '0; e_bwdata = '0; e_irdata = '0; e_mrdata = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!b.mem_req || e_mvalid) begin
        b.mem_req = $urandom_range(0, 2) != 0; b.mem_we = 1'($urandom_range(0, 1));
        b.mem_sel = 4'($urandom()); b.mem_addr = $urandom(); b.mem_wdata = $urandom();
      end
      if (!b.if_req || e_ivalid) begin
        b.if_req = $urandom_range(0, 2) != 0; b.if_addr = $urandom();
      end
      b.bus_ack = owner != 0 ? (cyc == gcyc + 1 + dly) : ($urandom_range(0, 3) == 0);
      b.bus_rdata = $urandom();
      e_stall = (b.mem_req && !e_mvalid) ? 6'b011111 : (b.if_req && !e_ivalid) ? 6'b000011 : 6'b0;
      #1;
      check($sformatf("r%0d_stall", i), 32'(b.stall), 32'(e_stall));
      nv_i = 1'b0; nv_m = 1'b0; e_err = 1'b0;
      if (owner == 0) begin
        de = b.mem_req && !e_mvalid;
        ie = b.if_req && !e_ivalid;
        if (de || ie) begin
          owner = (de && ie) ? (last_d ? 2 : 1) : (de ? 1 : 2);
          gcyc = cyc; dly = $urandom_range(0, 5); e_breq = 1'b1;
          e_bwe = owner == 1 && b.mem_we; e_bsel = b.mem_sel; e_bwdata = b.mem_wdata;
          e_baddr = owner == 1 ? b.mem_addr : b.if_addr;
        end
      end else if (b.bus_ack || cyc == gcyc + T) begin
        if (owner == 1) begin
          nv_m = 1'b1; e_mrdata = (b.bus_ack && !e_bwe) ? b.bus_rdata : 32'h0;
        end else begin
          nv_i = 1'b1; e_irdata = b.bus_ack ? b.bus_rdata : 32'h0;
        end
        e_err = !b.bus_ack; last_d = owner == 1; owner = 0; e_breq = 1'b0;
      end
      e_mvalid = nv_m; e_ivalid = nv_i; cyc++;
      tick();
      check($sformatf("r%0d_bus_req", i), 32'(b.bus_req), 32'(e_breq));
      check($sformatf("r%0d_mem_valid", i), 32'(b.mem_valid), 32'(e_mvalid));
      check($sformatf("r%0d_if_valid", i), 32'(b.if_valid), 32'(e_ivalid));
      check($sformatf("r%0d_bus_err", i), 32'(b.bus_err), 32'(e_err));
      if (e_mvalid) check($sformatf("r%0d_mem_rdata", i), b.mem_rdata, e_mrdata);
      if (e_ivalid) check($sformatf("r%0d_if_rdata", i), b.if_rdata, e_irdata);
      if (e_breq) begin
        check($sformatf("r%0d_bus_addr", i), b.bus_addr, e_baddr);
        check($sformatf("r%0d_bus_we", i), 32'(b.bus_we), 32'(e_bwe));
        if (owner == 1) begin
          check($sformatf("r%0d_bus_sel", i), 32'(b.bus_sel), 32'(e_bsel));
          check($sformatf("r%0d_bus_wdata", i), b.bus_wdata, e_bwdata);
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
